// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - round-robin arbiter with one-hot and binary grant outputs
//
// Grants one of OUT requesters at a time. The grant is held until the owner
// releases it, drops its request, enable goes low, or the hold counter
// reaches HOLD_MAX. The grant is driven as a registered binary index
// (grant_index) and a registered one-hot select (decoder_out).
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   enable         arbitration enable; low blocks new grants and revokes the current one
//   req[OUT]       level-sensitive per-requester request
//   grant_release  current owner is done; only looked at while a grant is active
//   grant_valid    a grant is active
//   grant_index    binary index of the owner; holds its last value while idle
//   decoder_out    one-hot grant, zero while idle

module rr_decoder_arbiter #(
    parameter int IN       = 3,
    parameter int OUT      = (1 << IN),
    parameter int HOLD_MAX = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [OUT-1:0] req,
    input  logic           grant_release,
    output logic           grant_valid,
    output logic [IN-1:0]  grant_index,
    output logic [OUT-1:0] decoder_out
);

    localparam int CW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [IN-1:0]   ptr;
    logic [CW-1:0]   hold_cnt;
    logic [IN-1:0]   winner;
    logic            any_req;
    logic            timeout;
    logic            grant_exit;

    // Scan from the farthest offset back to ptr so the requester closest to
    // ptr (in wrap-around order) is written last and wins. The IN-bit sum
    // wraps naturally modulo OUT.
    always_comb begin
        winner = '0;
        for (int i = OUT - 1; i >= 0; i--) begin
            if (req[ptr + IN'(i)]) begin
                winner = ptr + IN'(i);
            end
        end
    end

    assign any_req    = |req;
    assign timeout    = (HOLD_MAX != 0) && (hold_cnt == CW'(HOLD_MAX));
    assign grant_exit = grant_release || !req[grant_index] || !enable || timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
            decoder_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && any_req) begin
                        state       <= GRANT;
                        grant_valid <= 1'b1;
                        grant_index <= winner;
                        decoder_out <= OUT'(1) << winner;
                        hold_cnt    <= CW'(1);
                    end
                end
                GRANT: begin
                    if (grant_exit) begin
                        // All exit causes collapse into one exit with one
                        // pointer advance; a timed-out owner therefore
                        // ranks last on the next scan.
                        state       <= IDLE;
                        ptr         <= grant_index + IN'(1);
                        grant_valid <= 1'b0;
                        decoder_out <= '0;
                        hold_cnt    <= '0;
                    end else if (HOLD_MAX != 0 && hold_cnt != CW'(HOLD_MAX)) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                    decoder_out <= '0;
                    hold_cnt    <= '0;
                end
            endcase
        end
    end

endmodule
